boss_fire_control: RTL and testbench
====================================

BOSS_FIRE_CONTROL -- requirements
Module: boss_fire_control

Interface
REQ-001 Parameters: COOLDOWN_FRAMES, default 60, frame ticks between volleys; STAGGER_FRAMES, default 4, frame ticks between shots in a volley; START_LIVES, default 3, player lives at reset; INVULN_FRAMES, default 90, frame ticks of immunity after a hit.
REQ-002 Clk  in  1  system clock; all state updates on posedge Clk.
REQ-003 Reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 frame_clk  in  1  vertical-sync frame clock, asynchronous to Clk; used only as a tick source.
REQ-005 trigger  in  1  pseudo-random volley request, sampled on frame ticks only.
REQ-006 missile_active  in  3  per-boss-projectile busy flag, bit k high while boss projectile k is on screen.
REQ-007 player_hit  in  3  per-boss-projectile hitbox result against the player, level-sensitive.
REQ-008 boss_dead  in  1  boss has been destroyed.
REQ-009 fire  out  3  one-Clk-cycle launch pulse, bit k drives shoot of boss projectile k.
REQ-010 volley_busy  out  1  high in any state other than IDLE and HALT.
REQ-011 lives  out  2  remaining player lives.
REQ-012 invuln  out  1  high while the invulnerability counter is nonzero.
REQ-013 is_lost  out  1  sticky player-dead flag.

Function
REQ-014 frame_clk is passed through a 2-flop synchronizer plus one history flop; frame_tick is a 1-Clk pulse when sync2=1 and hist=0, 3 Clk cycles after the frame_clk rising edge.
REQ-015 State machine states: IDLE, FIRE0, GAP0, FIRE1, GAP1, FIRE2, COOLDOWN, HALT; all transitions except entry to HALT occur only on frame_tick.
REQ-016 IDLE -> FIRE0 on a tick with trigger=1; IDLE holds otherwise.
REQ-017 In FIRE_k, on a tick, fire[k] pulses that Clk cycle if missile_active[k]=0; if missile_active[k]=1 the shot is skipped and fire stays 0; the state advances either way (FIRE0->GAP0, FIRE1->GAP1, FIRE2->COOLDOWN).
REQ-018 GAP_k loads a frame counter with STAGGER_FRAMES on entry, decrements per tick, and advances to FIRE_(k+1) on the tick where the counter equals 1.
REQ-019 COOLDOWN does the same with COOLDOWN_FRAMES and returns to IDLE; trigger is ignored during COOLDOWN.
REQ-020 At most one fire bit is high in any cycle; fire is never high outside FIRE states.
REQ-021 A hit is registered in a Clk cycle when any player_hit bit is 1, invuln=0, and lives>0; lives decrements by exactly 1 at the next edge regardless of how many bits are set.
REQ-022 On a registered hit, the invulnerability counter loads INVULN_FRAMES at the same edge; it decrements on each tick while nonzero; hits while invuln=1 are ignored.
REQ-023 When lives reaches 0, is_lost sets at the same edge and holds until Reset; lives saturates at 0.
REQ-024 If is_lost=1 or boss_dead=1, the FSM enters HALT at the next Clk edge from any state, without waiting for a tick; HALT is terminal until Reset; fire=0 in HALT.
REQ-025 If a fire pulse and the HALT condition coincide, the fire pulse of that cycle is still emitted and HALT is entered at the next edge.
REQ-026 The counter width covers max(COOLDOWN_FRAMES, STAGGER_FRAMES, INVULN_FRAMES) and never underflows or wraps.

Reset
REQ-027 While Reset=1: state=IDLE, fire=000, volley_busy=0, lives=START_LIVES, invuln=0, is_lost=0, all counters and synchronizer flops cleared.
REQ-028 Reset asserted mid-volley or mid-invulnerability aborts it immediately; after release the first tick is detected only after a fresh frame_clk rising edge.

Verification
REQ-029 trigger=1 on a tick in IDLE, missile_active=000, defaults -> fire=001, 010, 100 pulses spaced 4 ticks apart, then 60 ticks of volley_busy=1, then IDLE.
REQ-030 missile_active=010 throughout the volley -> fire pulses only 001 and 100; timing identical to REQ-029.
REQ-031 player_hit=111 for 5 Clk cycles -> lives 3->2 once, invuln=1 for exactly 90 ticks; a hit on tick 50 is ignored; a hit after invuln=0 gives lives=1.
REQ-032 Three spaced hits -> lives=0, is_lost=1, FSM in HALT next cycle, no further fire pulses with trigger held at 1.
REQ-033 boss_dead=1 asserted during GAP1 -> HALT next edge, no fire[2] pulse, volley_busy=0.
REQ-034 Reset pulsed during COOLDOWN with lives=1 and invuln=1 -> all outputs at REQ-027 values asynchronously; the next trigger starts a new volley normally.

Source files
------------

// File: rtl/boss_fire_control.sv
// Boss volley sequencer: three staggered shots per volley on frame ticks, then a cooldown.
// Also tracks player lives, post-hit invulnerability and the terminal lost/boss-dead halt.
module boss_fire_control #(
  parameter int unsigned COOLDOWN_FRAMES = 60,
  parameter int unsigned STAGGER_FRAMES  = 4,
  parameter int unsigned START_LIVES     = 3,
  parameter int unsigned INVULN_FRAMES   = 90
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       trigger,
  input  logic [2:0] missile_active,
  input  logic [2:0] player_hit,
  input  logic       boss_dead,
  output logic [2:0] fire,
  output logic       volley_busy,
  output logic [1:0] lives,
  output logic       invuln,
  output logic       is_lost
);

  localparam int unsigned MAX_SG     = (COOLDOWN_FRAMES > STAGGER_FRAMES) ? COOLDOWN_FRAMES : STAGGER_FRAMES;
  localparam int unsigned MAX_FRAMES = (MAX_SG > INVULN_FRAMES) ? MAX_SG : INVULN_FRAMES;
  localparam int unsigned CNT_W      = (MAX_FRAMES < 2) ? 1 : $clog2(MAX_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRE0, S_GAP0, S_FIRE1, S_GAP1, S_FIRE2, S_COOLDOWN, S_HALT
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_inv_cnt;
  logic [1:0]       r_lives;
  logic             r_is_lost;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;

  logic             w_tick;
  logic             w_hit;
  logic             w_halt;
  logic [2:0]       w_fire;

  // Frame clock crosses into Clk; tick is the synchronized rising edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_tick = r_sync2 & ~r_hist;
  assign w_halt = r_is_lost | boss_dead;
  assign w_hit  = (|player_hit) && (r_inv_cnt == '0) && (r_lives != 2'd0);

  // Launch pulse is tied to the tick cycle so it lines up with the state advance.
  always_comb begin
    w_fire = 3'b000;
    if (w_tick) begin
      case (r_state)
        S_FIRE0: w_fire[0] = ~missile_active[0];
        S_FIRE1: w_fire[1] = ~missile_active[1];
        S_FIRE2: w_fire[2] = ~missile_active[2];
        default: w_fire    = 3'b000;
      endcase
    end
  end

  // Volley sequencer; halt overrides everything and needs no tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (w_halt) begin
      r_state <= S_HALT;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (trigger) r_state <= S_FIRE0;
        end
        S_FIRE0: begin
          r_state <= S_GAP0;
          r_cnt   <= CNT_W'(STAGGER_FRAMES);
        end
        S_GAP0: begin
          if (r_cnt <= CNT_W'(1)) r_state <= S_FIRE1;
          else                    r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_FIRE1: begin
          r_state <= S_GAP1;
          r_cnt   <= CNT_W'(STAGGER_FRAMES);
        end
        S_GAP1: begin
          if (r_cnt <= CNT_W'(1)) r_state <= S_FIRE2;
          else                    r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_FIRE2: begin
          r_state <= S_COOLDOWN;
          r_cnt   <= CNT_W'(COOLDOWN_FRAMES);
        end
        S_COOLDOWN: begin
          if (r_cnt <= CNT_W'(1)) r_state <= S_IDLE;
          else                    r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Lives and invulnerability; one hit per invulnerability window.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_lives   <= 2'(START_LIVES);
      r_inv_cnt <= '0;
      r_is_lost <= 1'b0;
    end else if (w_hit) begin
      r_lives   <= r_lives - 2'd1;
      r_inv_cnt <= CNT_W'(INVULN_FRAMES);
      if (r_lives == 2'd1) r_is_lost <= 1'b1;
    end else if (w_tick && (r_inv_cnt != '0)) begin
      r_inv_cnt <= r_inv_cnt - CNT_W'(1);
    end
  end

  assign fire        = w_fire;
  assign volley_busy = (r_state != S_IDLE) && (r_state != S_HALT);
  assign lives       = r_lives;
  assign invuln      = (r_inv_cnt != '0);
  assign is_lost     = r_is_lost;

endmodule

// File: tb/tb_boss_fire_control.sv
// Bench for boss_fire_control: tick-timeline reference model checked every cycle,
// directed volley/hit/halt/reset scenarios with literal timing pins, then random episodes.
module tb_boss_fire_control;

  localparam int COOL = 60;
  localparam int STAG = 4;
  localparam int LIV  = 3;
  localparam int INV  = 90;
  localparam int SHOT_GAP = STAG + 1;
  localparam int VOL_END  = 1 + 2 * SHOT_GAP + COOL;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       trigger;
  logic [2:0] missile_active;
  logic [2:0] player_hit;
  logic       boss_dead;
  logic [2:0] fire;
  logic       volley_busy;
  logic [1:0] lives;
  logic       invuln;
  logic       is_lost;

  boss_fire_control #(
    .COOLDOWN_FRAMES(COOL),
    .STAGGER_FRAMES (STAG),
    .START_LIVES    (LIV),
    .INVULN_FRAMES  (INV)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .trigger       (trigger),
    .missile_active(missile_active),
    .player_hit    (player_hit),
    .boss_dead     (boss_dead),
    .fire          (fire),
    .volley_busy   (volley_busy),
    .lives         (lives),
    .invuln        (invuln),
    .is_lost       (is_lost)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: volley as a timeline of ticks since the triggering tick.
  int m_lives;
  int m_inv;
  bit m_lost;
  bit m_halted;
  bit m_vol;
  int m_rel;
  bit f0, f1, f2;
  int g_tick = 0;

  int fp = 6;
  int fc_cnt = 0;
  bit cnt_inv_en = 0;
  int inv_ticks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_tick_cur();
    return f1 & ~f2;
  endfunction

  function automatic void model_clear();
    m_lives  = LIV;
    m_inv    = 0;
    m_lost   = 0;
    m_halted = 0;
    m_vol    = 0;
    m_rel    = 0;
    f0 = 0; f1 = 0; f2 = 0;
  endfunction

  function automatic void model_edge();
    bit tk, halt, hit;
    if (Reset) begin
      model_clear();
      return;
    end
    tk   = m_tick_cur();
    halt = m_lost | boss_dead;
    hit  = (player_hit != 3'b000) && (m_inv == 0) && (m_lives > 0);
    if (!m_halted) begin
      if (halt) begin
        m_halted = 1;
        m_vol    = 0;
      end else if (tk) begin
        if (m_vol) begin
          m_rel++;
          if (m_rel == VOL_END) m_vol = 0;
        end else if (trigger) begin
          m_vol = 1;
          m_rel = 0;
        end
      end
    end
    if (hit) begin
      m_lives--;
      m_inv = INV;
      if (m_lives == 0) m_lost = 1;
    end else if (tk && m_inv > 0) begin
      m_inv--;
    end
    if (tk) g_tick++;
    f2 = f1;
    f1 = f0;
    f0 = frame_clk;
  endfunction

  function automatic logic [2:0] exp_fire();
    logic [2:0] ef;
    ef = 3'b000;
    if (!m_halted && m_vol && m_tick_cur())
      for (int k = 0; k < 3; k++)
        if (m_rel + 1 == 1 + k * SHOT_GAP && !missile_active[k]) ef[k] = 1'b1;
    return ef;
  endfunction

  task automatic compare();
    chk("fire",        32'(fire),        32'(exp_fire()));
    chk("volley_busy", 32'(volley_busy), 32'(m_vol && !m_halted));
    chk("lives",       32'(lives),       32'(m_lives));
    chk("invuln",      32'(invuln),      32'(m_inv != 0));
    chk("is_lost",     32'(is_lost),     32'(m_lost));
  endtask

  // One Clk cycle: model follows the edge, outputs checked at the falling edge.
  task automatic step();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    compare();
    if (cnt_inv_en && invuln && m_tick_cur()) inv_ticks++;
    fc_cnt    = (fc_cnt + 1) % fp;
    frame_clk = (fc_cnt < fp / 2);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #3;
    Reset = 1'b1;
    model_clear();
    #1;
    chk("rst_fire",   32'(fire),        32'd0);
    chk("rst_busy",   32'(volley_busy), 32'd0);
    chk("rst_lives",  32'(lives),       32'd3);
    chk("rst_invuln", 32'(invuln),      32'd0);
    chk("rst_lost",   32'(is_lost),     32'd0);
    trigger = 0; player_hit = 0; boss_dead = 0; missile_active = 0;
    step();
    step();
    Reset = 1'b0;
  endtask

  // Hold trigger until a tick is pending in IDLE; returns its tick index.
  task automatic wait_start(output int s);
    trigger = 1;
    s = -1000;
    for (int i = 0; i < 200; i++) begin
      step();
      if (m_tick_cur()) begin
        s = g_tick;
        break;
      end
    end
    step();
    trigger = 0;
  endtask

  int vr[$];
  logic [2:0] vv[$];
  int idle_rel;

  task automatic run_volley(input logic [2:0] ma);
    int s;
    missile_active = ma;
    vr.delete();
    vv.delete();
    idle_rel = -1;
    wait_start(s);
    for (int i = 0; i < 1000; i++) begin
      step();
      if (fire != 3'b000) begin
        vr.push_back(g_tick - s);
        vv.push_back(fire);
      end
      if (!volley_busy) begin
        idle_rel = g_tick - s;
        break;
      end
    end
  endtask

  task automatic wait_invuln_clear();
    for (int i = 0; i < 2000 && invuln; i++) step();
    chk("invuln_clears", 32'(invuln), 32'd0);
  endtask

  task automatic hit_once();
    player_hit = 3'b111;
    step();
    player_hit = 3'b000;
    step();
  endtask

  int exp_r[$];
  int exp_v[$];

  task automatic check_volley(input string tag);
    chk({tag, "_nshots"}, 32'(vr.size()), 32'(exp_r.size()));
    for (int i = 0; i < exp_r.size(); i++) begin
      chk({tag, "_shot_tick"}, (i < vr.size()) ? 32'(vr[i]) : 32'hffffffff, 32'(exp_r[i]));
      chk({tag, "_shot_bits"}, (i < vv.size()) ? 32'(vv[i]) : 32'hffffffff, 32'(exp_v[i]));
    end
    // Third shot at tick 11, then 60 cooldown ticks before IDLE is visible.
    chk({tag, "_idle_tick"}, 32'(idle_rel), 32'd72);
  endtask

  initial begin
    int s, nf, burst, hit_div;
    Reset = 1'b1; frame_clk = 0; trigger = 0; missile_active = 0; player_hit = 0; boss_dead = 0;
    model_clear();
    do_reset();
    repeat (10) step();

    // Full volley, all launchers free
    run_volley(3'b000);
    exp_r = '{1, 6, 11};
    exp_v = '{1, 2, 4};
    check_volley("volley_free");

    // Middle launcher busy: that shot skipped, timing unchanged
    run_volley(3'b010);
    exp_r = '{1, 11};
    exp_v = '{1, 4};
    check_volley("volley_skip");
    missile_active = 0;

    // Held hit, invulnerability window, ignored hit, then a real hit
    do_reset();
    repeat (5) step();
    inv_ticks  = 0;
    cnt_inv_en = 1;
    player_hit = 3'b111;
    repeat (5) step();
    player_hit = 3'b000;
    chk("hit_lives", 32'(lives), 32'd2);
    for (int i = 0; i < 2000 && invuln; i++) begin
      step();
      if (inv_ticks == 50 && m_tick_cur()) begin
        player_hit = 3'b010;
        step();
        step();
        player_hit = 3'b000;
        chk("hit_in_invuln", 32'(lives), 32'd2);
      end
    end
    cnt_inv_en = 0;
    chk("invuln_ticks", 32'(inv_ticks), 32'd90);
    hit_once();
    chk("second_hit_lives", 32'(lives), 32'd1);

    // Last life lost: halt, nothing fires even with trigger held
    wait_invuln_clear();
    hit_once();
    chk("lost_lives", 32'(lives), 32'd0);
    chk("lost_flag",  32'(is_lost), 32'd1);
    trigger = 1;
    nf = 0;
    repeat (200) begin
      step();
      if (fire != 3'b000) nf++;
    end
    trigger = 0;
    chk("lost_no_fire", 32'(nf), 32'd0);
    chk("lost_busy",    32'(volley_busy), 32'd0);

    // Boss dies in the second gap: no third shot
    do_reset();
    repeat (5) step();
    wait_start(s);
    for (int i = 0; i < 500 && (g_tick - s) < 8; i++) step();
    boss_dead = 1;
    step();
    chk("dead_busy", 32'(volley_busy), 32'd0);
    nf = 0;
    repeat (100) begin
      step();
      if (fire != 3'b000) nf++;
    end
    boss_dead = 0;
    repeat (20) step();
    chk("dead_no_fire", 32'(nf), 32'd0);
    chk("dead_stays_halted", 32'(volley_busy), 32'd0);

    // Reset during cooldown with one life left and invulnerable
    do_reset();
    repeat (5) step();
    hit_once();
    wait_invuln_clear();
    hit_once();
    chk("pre_rst_lives", 32'(lives), 32'd1);
    wait_start(s);
    for (int i = 0; i < 500 && (g_tick - s) < 20; i++) step();
    chk("pre_rst_busy",   32'(volley_busy), 32'd1);
    chk("pre_rst_invuln", 32'(invuln), 32'd1);
    do_reset();
    repeat (5) step();
    run_volley(3'b000);
    exp_r = '{1, 6, 11};
    exp_v = '{1, 2, 4};
    check_volley("post_rst");

    // Random episodes
    for (int ep = 0; ep < 6; ep++) begin
      fp      = 4 + int'($urandom % 5);
      hit_div = 300 + int'($urandom % 600);
      do_reset();
      burst = 0;
      for (int c = 0; c < 3000; c++) begin
        trigger = ($urandom % 3 == 0);
        if ($urandom % 8 == 0) missile_active = 3'($urandom);
        if (burst > 0) begin
          burst--;
          player_hit = 3'($urandom_range(1, 7));
        end else begin
          player_hit = 3'b000;
          if ($urandom % hit_div == 0) burst = 1 + int'($urandom % 5);
        end
        if (ep % 2 == 1 && $urandom % 4000 == 0) boss_dead = 1;
        if ($urandom % 2500 == 0) do_reset();
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
